// File: rtl/byte_unstriping_pkg.sv
// byte_unstriping_pkg: mode codes and word lengths shared by byte_striping and byte_unstriping
package byte_unstriping_pkg;
    localparam logic [1:0] MODO8  = 2'b00;
    localparam logic [1:0] MODO16 = 2'b01;
    localparam logic [1:0] MODO32 = 2'b10;
    localparam logic [2:0] LEN8   = 3'd1;
    localparam logic [2:0] LEN16  = 3'd2;
    localparam logic [2:0] LEN32  = 3'd4;
    function automatic logic [2:0] word_len(input logic [1:0] s);
        return s == MODO16 ? LEN16 : s == MODO32 ? LEN32 : LEN8;
    endfunction
endpackage

// File: rtl/byte_unstriping.sv
// byte_unstriping: reassembles a serial byte stream (MSB byte first) into 8/16/32-bit words selected by S
module byte_unstriping
    import byte_unstriping_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enb,
    input  logic        valid_in,
    input  logic [7:0]  entrada8,
    input  logic [1:0]  S,
    output logic [7:0]  salida8,
    output logic [15:0] salida16,
    output logic [31:0] salida32,
    output logic        valid_out,
    output logic [1:0]  contador
);
    logic [1:0]       s_prev;
    logic [2:0][7:0]  acc;
    logic [2:0]       n;
    logic             chg;
    logic [1:0]       k;
    logic             last;
    always_comb begin
        n    = word_len(S);
        chg  = n != word_len(s_prev);
        k    = chg ? 2'd0 : contador;
        last = k == 2'(n - 3'd1);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_prev    <= 2'd0;
            acc       <= '0;
            contador  <= 2'd0;
            valid_out <= 1'b0;
            salida8   <= 8'd0;
            salida16  <= 16'd0;
            salida32  <= 32'd0;
        end else begin
            valid_out <= 1'b0;
            if (enb) begin
                s_prev   <= S;
                contador <= k;
                if (valid_in) begin
                    contador  <= last ? 2'd0 : k + 2'd1;
                    valid_out <= last;
                    if (!last) acc[k] <= entrada8;
                    else if (n == LEN8) salida8 <= entrada8;
                    else if (n == LEN16) salida16 <= {acc[0], entrada8};
                    else salida32 <= {acc[0], acc[1], acc[2], entrada8};
                end
            end
        end
    end
endmodule

// File: tb/tb_byte_unstriping.sv
// tb_byte_unstriping: directed self-checking bench for byte_unstriping
module tb_byte_unstriping;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enb = 1'b0;
    logic        valid_in = 1'b0;
    logic [7:0]  entrada8 = 8'd0;
    logic [1:0]  S = 2'b00;
    logic [7:0]  salida8;
    logic [15:0] salida16;
    logic [31:0] salida32;
    logic        valid_out;
    logic [1:0]  contador;
    int checks = 0;
    int errors = 0;
    byte_unstriping dut (
        .clk(clk), .reset(reset), .enb(enb), .valid_in(valid_in), .entrada8(entrada8), .S(S),
        .salida8(salida8), .salida16(salida16), .salida32(salida32), .valid_out(valid_out), .contador(contador)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic exp_all(input string tag, input logic vo, input logic [7:0] s8, input logic [15:0] s16,
                           input logic [31:0] s32, input logic [1:0] cnt);
        chk({tag, ".valid_out"}, 32'(valid_out), 32'(vo));
        chk({tag, ".salida8"}, 32'(salida8), 32'(s8));
        chk({tag, ".salida16"}, 32'(salida16), 32'(s16));
        chk({tag, ".salida32"}, salida32, s32);
        chk({tag, ".contador"}, 32'(contador), 32'(cnt));
    endtask
    task automatic cyc(input logic e, input logic v, input logic [1:0] s, input logic [7:0] d);
        enb = e;
        valid_in = v;
        S = s;
        entrada8 = d;
        @(posedge clk);
        #1;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp_all("reset", 1'b0, 8'h00, 16'h0000, 32'h0, 2'd0);
        cyc(1, 1, 2'b01, 8'h77);
        exp_all("pre_reset", 1'b0, 8'h00, 16'h0000, 32'h0, 2'd1);
        #2 reset = 1'b0;
        #1 exp_all("async_reset", 1'b0, 8'h00, 16'h0000, 32'h0, 2'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1, 1, 2'b01, 8'h9A);
        exp_all("post_reset_b0", 1'b0, 8'h00, 16'h0000, 32'h0, 2'd1);
        cyc(1, 1, 2'b01, 8'hBC);
        exp_all("post_reset_w16", 1'b1, 8'h00, 16'h9ABC, 32'h0, 2'd0);
        cyc(1, 1, 2'b00, 8'hA1);
        exp_all("m8_a1", 1'b1, 8'hA1, 16'h9ABC, 32'h0, 2'd0);
        cyc(1, 1, 2'b00, 8'hB2);
        exp_all("m8_b2", 1'b1, 8'hB2, 16'h9ABC, 32'h0, 2'd0);
        cyc(1, 1, 2'b11, 8'hC3);
        exp_all("m8_s11", 1'b1, 8'hC3, 16'h9ABC, 32'h0, 2'd0);
        cyc(1, 0, 2'b11, 8'h00);
        exp_all("m8_idle", 1'b0, 8'hC3, 16'h9ABC, 32'h0, 2'd0);
        cyc(1, 1, 2'b01, 8'h12);
        exp_all("m16_b0", 1'b0, 8'hC3, 16'h9ABC, 32'h0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 2'b01, 8'hEE);
            exp_all("m16_gap", 1'b0, 8'hC3, 16'h9ABC, 32'h0, 2'd1);
        end
        cyc(1, 1, 2'b01, 8'h34);
        exp_all("m16_w", 1'b1, 8'hC3, 16'h1234, 32'h0, 2'd0);
        cyc(1, 0, 2'b01, 8'h00);
        exp_all("m16_after", 1'b0, 8'hC3, 16'h1234, 32'h0, 2'd0);
        cyc(1, 1, 2'b10, 8'hDE);
        exp_all("m32_de", 1'b0, 8'hC3, 16'h1234, 32'h0, 2'd1);
        cyc(1, 1, 2'b10, 8'hAD);
        exp_all("m32_ad", 1'b0, 8'hC3, 16'h1234, 32'h0, 2'd2);
        cyc(1, 1, 2'b10, 8'hBE);
        exp_all("m32_be", 1'b0, 8'hC3, 16'h1234, 32'h0, 2'd3);
        cyc(1, 1, 2'b10, 8'hEF);
        exp_all("m32_w1", 1'b1, 8'hC3, 16'h1234, 32'hDEADBEEF, 2'd0);
        cyc(1, 1, 2'b10, 8'h01);
        exp_all("m32_01", 1'b0, 8'hC3, 16'h1234, 32'hDEADBEEF, 2'd1);
        cyc(1, 1, 2'b10, 8'h02);
        exp_all("m32_02", 1'b0, 8'hC3, 16'h1234, 32'hDEADBEEF, 2'd2);
        cyc(1, 1, 2'b10, 8'h03);
        exp_all("m32_03", 1'b0, 8'hC3, 16'h1234, 32'hDEADBEEF, 2'd3);
        cyc(1, 1, 2'b10, 8'h04);
        exp_all("m32_w2", 1'b1, 8'hC3, 16'h1234, 32'h01020304, 2'd0);
        cyc(1, 1, 2'b10, 8'h11);
        exp_all("chg_11", 1'b0, 8'hC3, 16'h1234, 32'h01020304, 2'd1);
        cyc(1, 1, 2'b10, 8'h22);
        exp_all("chg_22", 1'b0, 8'hC3, 16'h1234, 32'h01020304, 2'd2);
        cyc(1, 1, 2'b01, 8'h33);
        exp_all("chg_33", 1'b0, 8'hC3, 16'h1234, 32'h01020304, 2'd1);
        cyc(1, 1, 2'b01, 8'h44);
        exp_all("chg_w", 1'b1, 8'hC3, 16'h3344, 32'h01020304, 2'd0);
        cyc(1, 1, 2'b01, 8'h55);
        exp_all("enb_55", 1'b0, 8'hC3, 16'h3344, 32'h01020304, 2'd1);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 2'b01, 8'hFF);
            exp_all("enb_off", 1'b0, 8'hC3, 16'h3344, 32'h01020304, 2'd1);
        end
        cyc(1, 1, 2'b01, 8'h66);
        exp_all("enb_w", 1'b1, 8'hC3, 16'h5566, 32'h01020304, 2'd0);
        cyc(1, 0, 2'b01, 8'h00);
        exp_all("final", 1'b0, 8'hC3, 16'h5566, 32'h01020304, 2'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
